// File: rtl/mc_controller.sv
// mc_controller: multi-cycle LEGv8-subset control FSM with retired-instruction counter and sticky illegal flag
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             regWrite,
    output logic             memtoReg,
    output logic             reg2loc,
    output logic             aluSrc,
    output logic [1:0]       aluOp,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);
    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic [10:0]      opcode;
    logic             is_mem, is_cbz, is_rtype, retire, unused_bits;

    assign opcode      = instr[31:21];
    assign is_mem      = (opcode == 11'b11111000010) || (opcode == 11'b11111000000);
    assign is_cbz      = instr[31:24] == 8'b10110100;
    assign is_rtype    = opcode inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    assign unused_bits = ^instr[20:0];
    assign state       = state_q;
    assign instret     = instret_q;
    assign illegal     = illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        retire    = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                state_d   = is_mem ? MEMADR : is_cbz ? BRANCH : is_rtype ? EXEC : FETCH;
                illegal_d = illegal_q | ~(is_mem | is_cbz | is_rtype);
            end
            MEMADR: state_d = instr[22] ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  begin
                state_d = mem_ready ? FETCH : MEMWR;
                retire  = mem_ready;
            end
            EXEC:   state_d = ALUWB;
            MEMWB, ALUWB, BRANCH: retire = 1'b1;
            default: state_d = FETCH;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        regWrite = 1'b0;
        memtoReg = 1'b0;
        reg2loc  = 1'b0;
        aluSrc   = 1'b0;
        aluOp    = 2'b00;
        if (reset_n) begin
            case (state_q)
                FETCH:  begin
                    memRead = 1'b1;
                    irWrite = mem_ready;
                    pcWrite = mem_ready;
                end
                MEMADR: aluSrc = 1'b1;
                MEMRD:  begin
                    memRead = 1'b1;
                    aluSrc  = 1'b1;
                end
                MEMWB:  begin
                    regWrite = 1'b1;
                    memtoReg = 1'b1;
                end
                MEMWR:  begin
                    memWrite = 1'b1;
                    reg2loc  = 1'b1;
                    aluSrc   = 1'b1;
                end
                EXEC:   aluOp = 2'b10;
                ALUWB:  regWrite = 1'b1;
                BRANCH: begin
                    reg2loc = 1'b1;
                    aluOp   = 2'b01;
                    pcSrc   = 1'b1;
                    pcWrite = zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: instruction-level model of the multi-cycle controller, checked every cycle
module tb_mc_controller;
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8;
    localparam int C_LD = 0, C_ST = 1, C_CBZ = 2, C_R = 3, C_ILL = 4;

    logic        clk = 1'b0;
    logic        reset_n, zero, mem_ready;
    logic [31:0] instr;
    logic        memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite, memtoReg, reg2loc, aluSrc;
    logic [1:0]  aluOp;
    logic [3:0]  state;
    logic [31:0] instret;
    logic        illegal;
    logic        memRead4, memWrite4, irWrite4, pcWrite4, pcSrc4, regWrite4, memtoReg4, reg2loc4, aluSrc4;
    logic [1:0]  aluOp4;
    logic [3:0]  state4;
    logic [3:0]  instret4;
    logic        illegal4;
    logic [10:0] act, act4, exp_vec;
    logic [3:0]  exp_state;
    logic        exp_valid;
    int          n_tests = 0, n_fail = 0, m_instret = 0, cyc = 0;
    logic        m_illegal = 1'b0;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .regWrite(regWrite), .memtoReg(memtoReg), .reg2loc(reg2loc), .aluSrc(aluSrc), .aluOp(aluOp),
        .state(state), .instret(instret), .illegal(illegal)
    );

    mc_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .memRead(memRead4), .memWrite(memWrite4), .irWrite(irWrite4), .pcWrite(pcWrite4), .pcSrc(pcSrc4),
        .regWrite(regWrite4), .memtoReg(memtoReg4), .reg2loc(reg2loc4), .aluSrc(aluSrc4), .aluOp(aluOp4),
        .state(state4), .instret(instret4), .illegal(illegal4)
    );

    assign act  = {memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite, memtoReg, reg2loc, aluSrc, aluOp};
    assign act4 = {memRead4, memWrite4, irWrite4, pcWrite4, pcSrc4, regWrite4, memtoReg4, reg2loc4, aluSrc4, aluOp4};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // {memRead,memWrite,irWrite,pcWrite,pcSrc,regWrite,memtoReg,reg2loc,aluSrc,aluOp}
    function automatic logic [10:0] exp_out(input int ph, input logic z, input logic mr);
        case (ph)
            P_FETCH:  return {1'b1, 1'b0, mr, mr, 7'b0};
            P_MEMADR: return 11'b00000000100;
            P_MEMRD:  return 11'b10000000100;
            P_MEMWB:  return 11'b00000110000;
            P_MEMWR:  return 11'b01000001100;
            P_EXEC:   return 11'b00000000010;
            P_ALUWB:  return 11'b00000100000;
            P_BRANCH: return {3'b000, z, 1'b1, 2'b00, 1'b1, 1'b0, 2'b01};
            default:  return 11'b0;
        endcase
    endfunction

    function automatic int classify(input logic [31:0] ins);
        logic [10:0] op;
        op = ins[31:21];
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (ins[31:24] == 8'hB4) return C_CBZ;
        if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        return C_ILL;
    endfunction

    function automatic logic [31:0] mk(input logic [10:0] op);
        return {op, 21'h012345};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state", 32'(state), 32'(exp_state));
            chk("strobes", 32'(act), 32'(exp_vec));
            chk("instret", instret, 32'(m_instret));
            chk("illegal", 32'(illegal), 32'(m_illegal));
            chk("rd_wr_excl", 32'(memRead & memWrite), 32'd0);
            chk("state4", 32'(state4), 32'(exp_state));
            chk("strobes4", 32'(act4), 32'(exp_vec));
            chk("instret4", 32'(instret4), 32'(m_instret % 16));
        end
    end

    task automatic phase(input int ph, input logic mr);
        mem_ready = mr;
        exp_state = 4'(ph);
        exp_vec   = exp_out(ph, zero, mr);
        exp_valid = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw, input int lat);
        int cls;
        instr = ins;
        zero  = z;
        cyc   = 0;
        cls   = classify(ins);
        repeat (fw) phase(P_FETCH, 1'b0);
        phase(P_FETCH, 1'b1);
        phase(P_DECODE, 1'b0);
        case (cls)
            C_LD: begin
                phase(P_MEMADR, 1'b0);
                repeat (mw) phase(P_MEMRD, 1'b0);
                phase(P_MEMRD, 1'b1);
                phase(P_MEMWB, 1'b0);
                m_instret++;
            end
            C_ST: begin
                phase(P_MEMADR, 1'b0);
                repeat (mw) phase(P_MEMWR, 1'b0);
                phase(P_MEMWR, 1'b1);
                m_instret++;
            end
            C_CBZ: begin
                phase(P_BRANCH, 1'b0);
                m_instret++;
            end
            C_R: begin
                phase(P_EXEC, 1'b0);
                phase(P_ALUWB, 1'b0);
                m_instret++;
            end
            default: m_illegal = 1'b1;
        endcase
        chk("latency", 32'(cyc), 32'(lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        exp_valid = 1'b0;
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_strobes", 32'(act), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_instr(mk(11'b11111000010), 1'b0, 0, 0, 5);
        chk("ldur_instret", instret, 32'd1);
        run_instr(mk(11'b11111000000), 1'b0, 0, 3, 7);
        run_instr({8'hB4, 24'h000123}, 1'b1, 0, 0, 3);
        run_instr({8'hB4, 24'h000456}, 1'b0, 0, 0, 3);
        run_instr(mk(11'b11111000010), 1'b1, 2, 2, 9);
        chk("pre_illegal_instret", instret, 32'd5);
        run_instr(32'h0000_0000, 1'b0, 0, 0, 2);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("illegal_instret", instret, 32'd5);
        run_instr(mk(11'b10001011000), 1'b0, 0, 0, 4);
        chk("illegal_sticky", 32'(illegal), 32'd1);
        chk("add_instret", instret, 32'd6);
        run_instr(mk(11'b11001011000), 1'b0, 1, 0, 5);
        run_instr(mk(11'b10001010000), 1'b1, 0, 0, 4);
        run_instr(mk(11'b10101010000), 1'b0, 0, 0, 4);
        // abandon a load in MEMRD with an asynchronous reset pulse
        instr = mk(11'b11111000010);
        zero  = 1'b0;
        phase(P_FETCH, 1'b1);
        phase(P_DECODE, 1'b0);
        phase(P_MEMADR, 1'b0);
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        chk("pre_reset_state", 32'(state), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_strobes", 32'(act), 32'd0);
        chk("async_instret", instret, 32'd0);
        chk("async_illegal", 32'(illegal), 32'd0);
        chk("async_instret4", 32'(instret4), 32'd0);
        m_instret = 0;
        m_illegal = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_state", 32'(state), 32'd0);
        for (int i = 0; i < 16; i++) begin
            run_instr(mk(11'b10001011000), 1'b0, 0, 0, 4);
            if (i == 14) chk("instret4_max", 32'(instret4), 32'd15);
        end
        chk("instret4_wrap", 32'(instret4), 32'd0);
        chk("instret_16", instret, 32'd16);
        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  32  instruction register contents; opcode = instr[31:21].
REQ-005 zero  input  1  ALU zero flag, valid in BRANCH state.
REQ-006 mem_ready  input  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-007 memRead, memWrite  output  1 each  memory access strobes.
REQ-008 irWrite, pcWrite, pcSrc  output  1 each  IR load, PC load, PC source (0=PC+4, 1=branch target).
REQ-009 regWrite, memtoReg, reg2loc  output  1 each  register file controls.
REQ-010 aluSrc  output  1  0=register, 1=sign-extended immediate.
REQ-011 aluOp  output  2  00=add (address), 01=pass/compare (CBZ), 10=R-type funct.
REQ-012 state  output  4  current state encoding (debug).
REQ-013 instret  output  CNT_W  retired-instruction count.
REQ-014 illegal  output  1  sticky: set on undecodable opcode, cleared only by reset.

Function
REQ-015 States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8; codes 9-15 unreachable, SHALL recover to FETCH next cycle.
REQ-016 Decode: LDUR 11'b11111000010, STUR 11'b11111000000 -> MEMADR; instr[31:24]=8'b10110100 (CBZ) -> BRANCH; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC; any other -> FETCH, set illegal.
REQ-017 FETCH: memRead=1; if mem_ready=1: irWrite=1, pcWrite=1, pcSrc=0, -> DECODE; else hold FETCH, irWrite=pcWrite=0.
REQ-018 DECODE: all strobes 0; one cycle; next per REQ-016.
REQ-019 MEMADR: aluSrc=1, aluOp=00; -> MEMRD if LDUR, -> MEMWR if STUR (opcode bit 22).
REQ-020 MEMRD: memRead=1, aluSrc=1; stays until mem_ready=1, then -> MEMWB.
REQ-021 MEMWB: regWrite=1, memtoReg=1; -> FETCH.
REQ-022 MEMWR: memWrite=1, reg2loc=1, aluSrc=1; stays until mem_ready=1, then -> FETCH.
REQ-023 EXEC: aluSrc=0, aluOp=10; -> ALUWB.  ALUWB: regWrite=1, memtoReg=0; -> FETCH.
REQ-024 BRANCH: reg2loc=1, aluOp=01, pcSrc=1, pcWrite=zero (combinational); -> FETCH.
REQ-025 Strobes not listed for a state SHALL be 0 in that state; memRead and memWrite never both 1.
REQ-026 instret increments by 1 on the edge leaving MEMWB, ALUWB, BRANCH, or MEMWR (with mem_ready=1); not for illegal opcodes; wraps 2^CNT_W-1 -> 0.
REQ-027 Latency (mem_ready tied 1): LDUR 5 cycles, STUR 4, R-type 4, CBZ 3, illegal 2.
REQ-028 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-029 reset_n low SHALL immediately (asynchronously) force state=FETCH, instret=0, illegal=0, and all strobes 0 regardless of state decode.
REQ-030 After reset_n rises, first rising edge evaluates FETCH; reset mid-instruction abandons it without incrementing instret.

Verification
REQ-031 mem_ready=1, LDUR: state sequence 0,1,2,3,4,0; regWrite=memtoReg=1 only in state 4; instret 0->1.
REQ-032 STUR with mem_ready low 3 cycles in MEMWR: state holds 5 for 4 cycles, memWrite=1 throughout, instret increments once on exit.
REQ-033 CBZ with zero=1 -> pcWrite=1,pcSrc=1 in BRANCH; zero=0 -> pcWrite=0; both 3 cycles, instret +1 each.
REQ-034 instr=32'h0000_0000: DECODE -> FETCH, illegal=1 and stays 1 over following ADD; instret unchanged by illegal, +1 after ADD.
REQ-035 reset_n pulsed low during MEMRD: state=0, all strobes 0, instret=0 within same cycle; normal FETCH resumes after release.
REQ-036 CNT_W=4, 16 back-to-back R-type: instret wraps 15->0.
